// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Common data bus stage of the R10K out-of-order core. Each cycle it picks up
// to N finished functional-unit results with rotating priority. It registers
// them into N broadcast slots that are visible for exactly one cycle. The
// broadcast tags feed the complete list, the reservation-station wakeup logic
// and the physical register file write ports.
//
// Ports
//   clock      in   single clock, all state updates on posedge
//   reset      in   synchronous, active-high
//   flush      in   branch-mispredict squash: no grants, outputs and pointer cleared
//   fu_valid   in   [NUM_FU]          FU holds a finished result
//   fu_tag     in   [NUM_FU][TAG_W]   destination physical register per FU
//   fu_data    in   [NUM_FU][DATA_W]  result value per FU
//   fu_ready   out  [NUM_FU]          grant: FU result accepted this cycle
//   cdb_valid  out  [N]               broadcast slot valid
//   cdb_tag    out  [N][TAG_W]        broadcast tag, PHYS_REGS when slot invalid
//   cdb_data   out  [N][DATA_W]       broadcast value, 0 when slot invalid
// -----------------------------------------------------------------------------

`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module cdb_arbiter #(
  parameter int N         = `N,
  parameter int NUM_FU    = 6,
  parameter int PHYS_REGS = `PHYS_REG_SZ_R10K,
  parameter int DATA_W    = 32,
  // Tags must be able to hold PHYS_REGS itself, the "no tag" sentinel.
  localparam int TAG_W    = $clog2(PHYS_REGS + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
  output logic [N-1:0]                   cdb_valid,
  output logic [N-1:0][TAG_W-1:0]        cdb_tag,
  output logic [N-1:0][DATA_W-1:0]       cdb_data
);

  localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(PHYS_REGS);

  logic [PTR_W-1:0]             rr_ptr;
  logic [PTR_W-1:0]             rr_ptr_next;
  logic [N-1:0]                 slot_valid;
  logic [N-1:0][TAG_W-1:0]      slot_tag;
  logic [N-1:0][DATA_W-1:0]     slot_data;
  logic [PTR_W-1:0]             fu_sel;
  logic [SLOT_W-1:0]            slot_sel;

  // Circular scan starting at rr_ptr. The k-th valid FU found goes to slot k
  // until N slots are filled. fu_ready is a pure function of fu_valid, rr_ptr
  // and flush, so there is no combinational loop through the FU handshake.
  always_comb begin : arbitrate
    int idx;
    int granted;
    // NOTE: every output of this block gets a default before the loop; a
    // path that skips an assignment would otherwise infer a latch.
    fu_ready    = '0;
    slot_valid  = '0;
    slot_tag    = {N{NO_TAG}};
    slot_data   = '0;
    rr_ptr_next = rr_ptr;
    fu_sel      = '0;
    slot_sel    = '0;
    granted     = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      fu_sel   = idx[PTR_W-1:0];
      slot_sel = granted[SLOT_W-1:0];
      if (!flush && fu_valid[fu_sel] && granted < N) begin
        fu_ready[fu_sel]    = 1'b1;
        slot_valid[slot_sel] = 1'b1;
        slot_tag[slot_sel]   = fu_tag[fu_sel];
        slot_data[slot_sel]  = fu_data[fu_sel];
        // Pointer lands just past the last FU granted, wrapping explicitly so
        // non-power-of-two NUM_FU works.
        rr_ptr_next = (idx == NUM_FU - 1) ? '0 : PTR_W'(idx + 1);
        granted     = granted + 1;
      end
    end
  end

  // Reset and flush have the same effect on state: the next cycle's slots are
  // empty and priority restarts at FU 0. Whatever is already on the bus this
  // cycle stays visible until the edge.
  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset || flush) begin
      cdb_valid <= '0;
      cdb_tag   <= {N{NO_TAG}};
      cdb_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      cdb_valid <= slot_valid;
      cdb_tag   <= slot_tag;
      cdb_data  <= slot_data;
      rr_ptr    <= rr_ptr_next;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter with N=2, NUM_FU=4, PHYS_REGS=64.
// Each cycle, the bench computes the slots it expects from a small model of
// rotating priority. It pushes these slots to a queue and compares them with
// the CDB one edge later. Scenario tasks add fixed expected values for reset,
// single result, saturation, wrap, back-pressure and flush. A random phase
// emulates FUs that hold each result until they are granted.
// -----------------------------------------------------------------------------

module tb_cdb_arbiter;

  localparam int N         = 2;
  localparam int NUM_FU    = 4;
  localparam int PHYS_REGS = 64;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 7;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          flush;
  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0]             fu_ready;
  logic [N-1:0]                  cdb_valid;
  logic [N-1:0][TAG_W-1:0]       cdb_tag;
  logic [N-1:0][DATA_W-1:0]      cdb_data;

  always #5 clock = ~clock;

  cdb_arbiter #(
    .N(N), .NUM_FU(NUM_FU), .PHYS_REGS(PHYS_REGS), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  typedef struct packed {
    logic [N-1:0]             v;
    logic [N-1:0][TAG_W-1:0]  tag;
    logic [N-1:0][DATA_W-1:0] data;
  } slots_t;

  slots_t           exp_q[$];
  int               compared   = 0;
  int               mismatched = 0;
  int               m_ptr      = 0;   // model of the round-robin pointer
  logic [NUM_FU-1:0] ready_seen;      // fu_ready sampled mid-cycle
  slots_t           pre_cdb;          // CDB contents sampled mid-cycle
  int               tag7_count;

  // One clock cycle: drive at negedge, sample grants, predict, then compare
  // the registered CDB and pointer just after the posedge.
  task automatic cycle(input logic [NUM_FU-1:0] valid, input logic fl, input logic rst);
    slots_t e;
    slots_t got;
    logic [NUM_FU-1:0] g;
    int cnt;
    int last;
    int i;
    @(negedge clock);
    fu_valid = valid;
    flush    = fl;
    reset    = rst;
    #1;
    ready_seen = fu_ready;
    pre_cdb    = {cdb_valid, cdb_tag, cdb_data};
    e.v    = '0;
    e.tag  = {N{TAG_W'(PHYS_REGS)}};
    e.data = '0;
    g      = '0;
    cnt    = 0;
    last   = 0;
    if (!fl) begin
      for (int k = 0; k < NUM_FU; k++) begin
        i = (m_ptr + k) % NUM_FU;
        if (valid[i] && cnt < N) begin
          g[i]        = 1'b1;
          e.v[cnt]    = 1'b1;
          e.tag[cnt]  = fu_tag[i];
          e.data[cnt] = fu_data[i];
          last        = i;
          cnt++;
        end
      end
    end
    if (!rst) begin
      compared++;
      if (fu_ready !== g) begin
        mismatched++;
        $display("FAIL fu_ready: got %b expected %b (valid %b flush %b)", fu_ready, g, valid, fl);
      end
    end
    if (rst || fl) begin
      e.v    = '0;
      e.tag  = {N{TAG_W'(PHYS_REGS)}};
      e.data = '0;
      m_ptr  = 0;
    end else if (cnt > 0) begin
      m_ptr = (last + 1) % NUM_FU;
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got = {cdb_valid, cdb_tag, cdb_data};
    e   = exp_q.pop_front();
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL cdb_slots: got v=%b tag=%0d/%0d data=%h/%h expected v=%b tag=%0d/%0d data=%h/%h",
               got.v, got.tag[0], got.tag[1], got.data[0], got.data[1],
               e.v, e.tag[0], e.tag[1], e.data[0], e.data[1]);
    end
    compared++;
    if (dut.rr_ptr !== 2'(m_ptr)) begin
      mismatched++;
      $display("FAIL rr_ptr: got %0d expected %0d", dut.rr_ptr, m_ptr);
    end
    for (int s = 0; s < N; s++)
      if (cdb_valid[s] && cdb_tag[s] == 7'd7) tag7_count++;
  endtask

  task automatic set_fu(input int i, input int tag, input logic [DATA_W-1:0] data);
    fu_tag[i]  = TAG_W'(tag);
    fu_data[i] = data;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 40 + i, 32'h1000 + i);
    cycle(4'b1111, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b1);
    compared++;
    if (cdb_valid !== 2'b00 || cdb_tag[0] !== 7'd64 || cdb_tag[1] !== 7'd64 || cdb_data !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got v=%b tags %0d/%0d expected v=00 tags 64/64 data 0",
               cdb_valid, cdb_tag[0], cdb_tag[1]);
    end
    cycle(4'b0000, 1'b0, 1'b0);
    compared++;
    if (dut.rr_ptr !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_ptr: got %0d expected 0", dut.rr_ptr);
    end
  endtask

  task automatic test_single();
    set_fu(2, 17, 32'hDEAD);
    cycle(4'b0100, 1'b0, 1'b0);
    compared++;
    if (ready_seen !== 4'b0100) begin
      mismatched++;
      $display("FAIL single_ready: got %b expected 0100", ready_seen);
    end
    compared++;
    if (cdb_valid !== 2'b01 || cdb_tag[0] !== 7'd17 || cdb_data[0] !== 32'hDEAD ||
        cdb_tag[1] !== 7'd64 || dut.rr_ptr !== 2'd3) begin
      mismatched++;
      $display("FAIL single_cdb: got v=%b tag0=%0d data0=%h tag1=%0d ptr=%0d expected v=01 17 dead 64 ptr=3",
               cdb_valid, cdb_tag[0], cdb_data[0], cdb_tag[1], dut.rr_ptr);
    end
  endtask

  task automatic test_saturation();
    logic [NUM_FU-1:0] exp_ready[3];
    int exp_t0[3];
    int exp_t1[3];
    exp_ready = '{4'b0011, 4'b1100, 4'b0011};
    exp_t0    = '{20, 22, 20};
    exp_t1    = '{21, 23, 21};
    cycle(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 20 + i, 32'hA000 + i);
    for (int c = 0; c < 3; c++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      compared++;
      if (ready_seen !== exp_ready[c] || cdb_tag[0] !== 7'(exp_t0[c]) || cdb_tag[1] !== 7'(exp_t1[c])) begin
        mismatched++;
        $display("FAIL saturation_%0d: got ready %b tags %0d/%0d expected %b %0d/%0d",
                 c, ready_seen, cdb_tag[0], cdb_tag[1], exp_ready[c], exp_t0[c], exp_t1[c]);
      end
    end
  endtask

  task automatic test_wrap();
    cycle(4'b0000, 1'b1, 1'b0);
    set_fu(2, 12, 32'h2);
    cycle(4'b0100, 1'b0, 1'b0);   // leaves rr_ptr at 3
    set_fu(3, 33, 32'h33);
    set_fu(0, 30, 32'h30);
    cycle(4'b1001, 1'b0, 1'b0);
    compared++;
    if (ready_seen !== 4'b1001 || cdb_tag[0] !== 7'd33 || cdb_tag[1] !== 7'd30 || dut.rr_ptr !== 2'd1) begin
      mismatched++;
      $display("FAIL wrap: got ready %b tags %0d/%0d ptr %0d expected 1001 33/30 ptr 1",
               ready_seen, cdb_tag[0], cdb_tag[1], dut.rr_ptr);
    end
  endtask

  task automatic test_back_to_back();
    cycle(4'b0000, 1'b1, 1'b0);
    set_fu(0, 5, 32'h55);
    set_fu(1, 6, 32'h66);
    set_fu(2, 7, 32'h77);
    tag7_count = 0;
    cycle(4'b0111, 1'b0, 1'b0);
    compared++;
    if (ready_seen !== 4'b0011) begin
      mismatched++;
      $display("FAIL backpressure_grant0: got %b expected 0011", ready_seen);
    end
    cycle(4'b0100, 1'b0, 1'b0);   // FU2 still holding tag 7
    compared++;
    if (ready_seen !== 4'b0100 || cdb_valid !== 2'b01 || cdb_tag[0] !== 7'd7) begin
      mismatched++;
      $display("FAIL backpressure_grant1: got ready %b v=%b tag0=%0d expected 0100 01 7",
               ready_seen, cdb_valid, cdb_tag[0]);
    end
    cycle(4'b0000, 1'b0, 1'b0);
    compared++;
    if (tag7_count !== 1) begin
      mismatched++;
      $display("FAIL backpressure_once: tag 7 broadcast %0d times expected 1", tag7_count);
    end
  endtask

  task automatic test_flush();
    cycle(4'b0000, 1'b1, 1'b0);
    set_fu(0, 9, 32'h9);
    set_fu(1, 10, 32'hA);
    set_fu(2, 11, 32'hB);
    set_fu(3, 12, 32'hC);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0);
    compared++;
    if (ready_seen !== 4'b0000 || pre_cdb.v !== 2'b11 || pre_cdb.tag[0] !== 7'd9 || pre_cdb.tag[1] !== 7'd10) begin
      mismatched++;
      $display("FAIL flush_cycle: got ready %b v=%b tags %0d/%0d expected 0000 11 9/10",
               ready_seen, pre_cdb.v, pre_cdb.tag[0], pre_cdb.tag[1]);
    end
    compared++;
    if (cdb_valid !== 2'b00 || dut.rr_ptr !== 2'd0) begin
      mismatched++;
      $display("FAIL flush_after: got v=%b ptr %0d expected 00 ptr 0", cdb_valid, dut.rr_ptr);
    end
  endtask

  // FUs raise results at random and hold them until granted; each one must be
  // served within ceil(NUM_FU/N) = 2 cycles.
  task automatic test_random();
    logic [NUM_FU-1:0] pending;
    int wait_cyc[NUM_FU];
    int next_tag;
    pending  = '0;
    next_tag = 1;
    for (int i = 0; i < NUM_FU; i++) wait_cyc[i] = 0;
    cycle(4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!pending[i] && $urandom_range(0, 3) != 0) begin
          pending[i] = 1'b1;
          set_fu(i, next_tag, $urandom);
          next_tag   = (next_tag % 60) + 1;
          wait_cyc[i] = 0;
        end
      end
      cycle(pending, 1'b0, 1'b0);
      for (int i = 0; i < NUM_FU; i++) begin
        if (pending[i]) begin
          wait_cyc[i]++;
          if (ready_seen[i]) pending[i] = 1'b0;
          else begin
            compared++;
            if (wait_cyc[i] >= 2) begin
              mismatched++;
              $display("FAIL fairness: FU%0d waited %0d cycles without grant, limit 2", i, wait_cyc[i]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    fu_valid = '1;
    fu_tag   = '0;
    fu_data  = '0;
    tag7_count = 0;
    test_reset();
    test_single();
    test_saturation();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
